// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings, defaults and range helper for mem_arbiter
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_RMW_RD = 2'd2,
        ST_WR     = 2'd3
    } state_t;

    localparam logic [31:0] DEF_START_ADDR = 32'h0100_0000;
    localparam int          DEF_MEM_SIZE   = 1048576;

    // Access width in bytes; the reserved size code 11 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // True when any byte of the access falls outside [base, base+span-1].
    // Evaluated in 33 bits so accesses near 2^32 cannot wrap into range.
    function automatic logic out_of_range(input logic [31:0] addr, input logic [1:0] size,
                                          input logic [31:0] base, input int unsigned span);
        logic [32:0] last_byte;
        logic [32:0] last_valid;
        last_byte  = {1'b0, addr} + 33'(size_bytes(size)) - 33'd1;
        last_valid = {1'b0, base} + 33'(span) - 33'd1;
        return (addr < base) || (last_byte > last_valid);
    endfunction

endpackage

// File: rtl/mem_arb_merge.sv
// rtl/mem_arb_merge.sv - combinational store merge of old word and right-aligned store data
import mem_arb_pkg::*;

module mem_arb_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    logic [31:0] lane_mask;

    // Select the byte lanes taken from the store data; the rest keep the old word.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        merged = (wdata & lane_mask) | (old_word & ~lane_mask);
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter and sequencer for memory; MEM_ARB_ADDR_CHECK_EN enables range errors
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter logic [31:0] START_ADDR     = DEF_START_ADDR,
    parameter int          MEM_SIZE       = DEF_MEM_SIZE,
    parameter int          FETCH_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    input  logic [31:0] mem_data_out
);

    localparam int             WCW      = $clog2(FETCH_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(FETCH_MAX_WAIT);

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    state_t         state;
    state_t         state_next;
    logic [WCW-1:0] wait_cnt;
    logic           owner_fetch;
    logic [1:0]     lat_size;
    logic [31:0]    lat_wdata;
    logic [31:0]    old_word;
    logic [31:0]    merged;
    logic           fetch_wins;
    logic           oor_f;
    logic           oor_d;

    // With the check disabled these are constant 0, so both err outputs stay tied low.
    assign oor_f = ADDR_CHECK && out_of_range(if_addr, SZ_WORD, START_ADDR, MEM_SIZE);
    assign oor_d = ADDR_CHECK && out_of_range(d_addr, d_size, START_ADDR, MEM_SIZE);

    mem_arb_merge u_merge (
        .old_word (old_word),
        .wdata    (lat_wdata),
        .size     (lat_size),
        .merged   (merged)
    );

    // Write strobe and data are decoded from state so an async reset kills a write at once.
    assign mem_w_enable = (state == ST_WR);
    assign mem_data_in  = (state == ST_WR) ? merged : 32'h0;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Arbitration and next-state: data wins unless fetch has waited its limit.
    always_comb begin
        state_next = state;
        if_ready   = 1'b0;
        d_ready    = 1'b0;
        fetch_wins = if_req && (!d_req || (wait_cnt >= WAIT_MAX));
        case (state)
            ST_IDLE: begin
                if_ready = fetch_wins;
                d_ready  = d_req && !fetch_wins;
                if (if_ready) begin
                    state_next = oor_f ? ST_IDLE : ST_RD;
                end else if (d_ready) begin
                    if (oor_d)                                    state_next = ST_IDLE;
                    else if (!d_we)                               state_next = ST_RD;
                    else if (d_size == SZ_BYTE || d_size == SZ_HALF) state_next = ST_RMW_RD;
                    else                                          state_next = ST_WR;
                end
            end
            ST_RD:     state_next = ST_IDLE;
            ST_RMW_RD: state_next = ST_WR;
            ST_WR:     state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Fetch wait counter: saturating while fetch is held off, cleared on fetch grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            wait_cnt <= '0;
        else if (if_ready)                       wait_cnt <= '0;
        else if (if_req && wait_cnt < WAIT_MAX)  wait_cnt <= wait_cnt + 1'b1;
    end

    // Request latching, memory address, read capture and completion pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_fetch <= 1'b0;
            lat_size    <= SZ_WORD;
            lat_wdata   <= 32'h0;
            old_word    <= 32'h0;
            mem_address <= START_ADDR;
            if_valid    <= 1'b0;
            if_err      <= 1'b0;
            if_rdata    <= 32'h0;
            d_valid     <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= 32'h0;
        end else begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_ready) begin
                        if (oor_f) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= 32'h0;
                        end else begin
                            owner_fetch <= 1'b1;
                            mem_address <= if_addr;
                        end
                    end else if (d_ready) begin
                        if (oor_d) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'h0;
                        end else begin
                            owner_fetch <= 1'b0;
                            mem_address <= d_addr;
                            lat_size    <= d_size;
                            lat_wdata   <= d_wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (owner_fetch) begin
                        if_rdata <= mem_data_out;
                        if_valid <= 1'b1;
                    end else begin
                        d_rdata <= mem_data_out;
                        d_valid <= 1'b1;
                    end
                end
                ST_RMW_RD: old_word <= mem_data_out;
                ST_WR:     d_valid  <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the unified byte-addressed `memory` block, shared between the instruction-fetch port and the load/store port of the CPU. It grants one requester at a time and drives `memory`'s address, data and write-enable. Sub-word stores are performed as read-modify-write, because `memory` always writes four bytes. A starvation guard bounds how long fetch waits behind data traffic.

## Interface
- `START_ADDR`, 32'h01000000, lowest valid byte address
- `MEM_SIZE`, 1048576, memory size in bytes
- `FETCH_MAX_WAIT`, 4, cycles fetch may be denied before it is forced to win (≥1)
- `clk` in 1 – single clock, all state on posedge
- `reset_n` in 1 – asynchronous, active-low reset
- `if_req` in 1 – fetch request; held stable until accepted
- `if_addr` in 32 – fetch byte address
- `if_ready` out 1 – fetch request accepted this cycle
- `if_valid` out 1 – one-cycle pulse, `if_rdata` valid
- `if_rdata` out 32 – fetched word
- `if_err` out 1 – qualifies `if_valid`; address out of range
- `d_req` in 1 – data request; held stable until accepted
- `d_we` in 1 – 1 = store, 0 = load
- `d_size` in 2 – 00 byte, 01 half, 10 word, 11 treated as word
- `d_addr` in 32 – data byte address
- `d_wdata` in 32 – store data, right-aligned
- `d_ready` out 1 – data request accepted this cycle
- `d_valid` out 1 – one-cycle completion pulse for loads and stores
- `d_rdata` out 32 – raw word at `d_addr` (bytes addr..addr+3, addr in [7:0]); extension is done by the CPU
- `d_err` out 1 – qualifies `d_valid`
- `mem_address` out 32, `mem_data_in` out 32, `mem_w_enable` out 1 – connect to `memory`
- `mem_data_out` in 32 – `memory` read data (combinational from address)

## Operation
- States: IDLE, RD, RMW_RD, WR.
- IDLE: a request is accepted when `req && ready`. Address, size, we and wdata are latched on acceptance.
  - Accepted load/fetch → RD.
  - Word store → WR.
  - Byte/half store → RMW_RD.
- RD: drives the latched address, `mem_w_enable`=0. `mem_data_out` is registered into the owner's rdata. Goes to IDLE, and the owner's valid is high the following cycle.
- RMW_RD: drives the address with `mem_w_enable`=0 and latches the old word → WR.
- WR: `mem_data_in` is the merged word.
  - Byte store: {old[31:8], wdata[7:0]}.
  - Half store: {old[31:16], wdata[15:0]}.
  - Word store: wdata.
  - `mem_w_enable`=1 only in WR → IDLE; `d_valid` pulses the next cycle.
- Arbitration (IDLE only, combinational `ready`):
  - Data wins over fetch, unless `wait_cnt` ≥ `FETCH_MAX_WAIT`; then fetch wins.
  - Only one `ready` is ever high.
  - Both `ready` are 0 outside IDLE.
- `wait_cnt`, width $clog2(FETCH_MAX_WAIT+1):
  - Increments, saturating, each cycle `if_req` is high and `if_ready` is low.
  - Clears when fetch is accepted.
- `mem_address` holds its last value in IDLE. `mem_data_in` is 0 outside WR.

## Timing
- Accept at cycle N. Valid at:
  - N+2 for load, fetch and word store.
  - N+3 for sub-word store.
- IDLE may accept a new request in the same cycle a valid pulses. Back-to-back loads give one result every 2 cycles.
- Reset values: state IDLE; `if_valid`, `d_valid`, `if_err`, `d_err`, `mem_w_enable` = 0; `if_rdata`, `d_rdata`, `mem_data_in` = 0; `mem_address` = `START_ADDR`; `wait_cnt` = 0.
- Reset asserted mid-transaction: the transaction is aborted, no valid is issued, and `mem_w_enable` drops immediately, so no write occurs.
- Simultaneous requests with `wait_cnt` saturated: fetch is granted and data waits, so data is delayed at most one transaction.

## Configuration
- `MEM_ARB_ADDR_CHECK_EN` defined:
  - A request is out of range if addr < `START_ADDR` or addr+bytes−1 > `START_ADDR`+`MEM_SIZE`−1, with bytes = 1/2/4 and fetch = 4.
  - Out-of-range requests are accepted, skip the memory states, and return valid at N+1 with err=1 and rdata=0.
  - No write occurs.
- Not defined: no check is made; `if_err` and `d_err` are tied 0.

## Structure
- Package `mem_arb_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State encodings `ST_IDLE`, `ST_RD`, `ST_RMW_RD`, `ST_WR`.
  - Default `START_ADDR` and `MEM_SIZE`.
- One sub-module, `mem_arb_merge`: combinational store-merge of (old word, wdata, size) → write word.

## Test plan
- Fetch at 0x01000000, preload word 0x00500093, no data req → `if_ready` N, `if_valid` N+2, `if_rdata`=0x00500093, no `mem_w_enable`.
- Byte store 0xAB at 0x01000010, old word 0x11223344 → one RMW_RD cycle then WR with `mem_data_in`=0x112233AB, `d_valid` N+3; a reload returns 0x112233AB.
- Half store 0xBEEF to 0x01000012, then word load from 0x01000010 → `d_rdata`=0xBEEF33AB (byte addr+3..addr, addr in [7:0]).
- `if_req` and `d_req` held continuously, `FETCH_MAX_WAIT`=4 → data granted until fetch has waited 4 cycles; fetch is then granted and `wait_cnt` clears.
- Assert `reset_n`=0 during WR of a word store 0xDEADBEEF → `mem_w_enable` drops at once, the memory word is unchanged, and all outputs are at reset values.
- With `MEM_ARB_ADDR_CHECK_EN`: word load at 0x010FFFFE → `d_valid` N+1, `d_err`=1, `d_rdata`=0. Without the macro → normal RD path, `d_err`=0.
